// File: rtl/product_accumulator.sv
// product_accumulator: sums the unsigned product stream from param_multiplier
// into one dot-product result per frame and presents it on a valid/ready port.
// A frame ends on in_last or on the LEN-th accepted product.
module product_accumulator #(
    parameter int WIDTH     = 8,
    parameter int LEN       = 4,
    parameter int ACC_WIDTH = 18,
    localparam int CW       = $clog2(LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CW-1:0]        out_count,
    output logic                 out_overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               state, state_n;
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        count;
    logic                 ovf;
    logic                 in_xfer, out_xfer, frame_end;
    logic [ACC_WIDTH:0]   sum_w;

    // Handshake decode; the extra top bit of sum_w is the carry-out of the add.
    always_comb begin
        in_ready  = rst_n && (state != HOLD);
        out_valid = (state == HOLD);
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
        frame_end = in_xfer && (in_last || (count == CW'(LEN - 1)));
        sum_w     = {1'b0, acc} + (ACC_WIDTH + 1)'(in_product);
    end

    // Result outputs are forced to zero whenever no result is presented.
    always_comb begin
        out_sum      = out_valid ? acc   : '0;
        out_count    = out_valid ? count : '0;
        out_overflow = out_valid && ovf;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic; clear overrides every handshake.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, ACCUM: if (in_xfer) state_n = frame_end ? HOLD : ACCUM;
            HOLD:        if (out_xfer) state_n = IDLE;
            default:     state_n = IDLE;
        endcase
        if (clear) state_n = IDLE;
    end

    // Accumulator, beat counter and sticky overflow; reset at frame hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear || out_xfer) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (in_xfer) begin
            acc   <= sum_w[ACC_WIDTH-1:0];
            count <= count + CW'(1);
            ovf   <= ovf | sum_w[ACC_WIDTH];
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (ACC_WIDTH 18 and 16) share one
// stimulus stream; a frame-level model predicts every output each cycle.
module tb_product_accumulator;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_overflow;
    logic [17:0] a_out_sum;
    logic [2:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [15:0] b_out_sum;
    logic [2:0]  b_out_count;

    int vectors = 0;
    int miscompares = 0;

    product_accumulator #(.WIDTH(8), .LEN(LEN), .ACC_WIDTH(18)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
        .out_count(a_out_count), .out_overflow(a_out_overflow));

    product_accumulator #(.WIDTH(8), .LEN(LEN), .ACC_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
        .out_count(b_out_count), .out_overflow(b_out_overflow));

    always #5 clk = ~clk;

    // Frame model: unbounded running sum of the open frame, plus the pending result.
    logic [63:0] msum = '0, rsum = '0;
    int          mcnt = 0, rcnt = 0;
    bit          pend = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msum <= '0; mcnt <= 0; pend <= 1'b0; rsum <= '0; rcnt <= 0;
        end else if (clear) begin
            msum <= '0; mcnt <= 0; pend <= 1'b0;
        end else if (pend) begin
            if (out_ready) pend <= 1'b0;
        end else if (in_valid) begin
            if (in_last || mcnt + 1 == LEN) begin
                pend <= 1'b1; rsum <= msum + 64'(in_product); rcnt <= mcnt + 1;
                msum <= '0; mcnt <= 0;
            end else begin
                msum <= msum + 64'(in_product); mcnt <= mcnt + 1;
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        logic [17:0] ea_sum;
        logic [15:0] eb_sum;
        logic        ea_ovf, eb_ovf, e_rdy;
        logic [2:0]  e_cnt;
        e_rdy  = rst_n && !pend;
        ea_sum = pend ? 18'(rsum % 64'd262144) : '0;
        eb_sum = pend ? 16'(rsum % 64'd65536) : '0;
        ea_ovf = pend && (rsum >= 64'd262144);
        eb_ovf = pend && (rsum >= 64'd65536);
        e_cnt  = pend ? 3'(rcnt) : '0;
        vectors += 2;
        if ({a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_overflow} !==
            {e_rdy, pend, ea_sum, e_cnt, ea_ovf}) begin
            miscompares++;
            $display("FAIL model_a t=%0t got rdy=%b v=%b sum=%0d cnt=%0d ovf=%b exp rdy=%b v=%b sum=%0d cnt=%0d ovf=%b",
                     $time, a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_overflow,
                     e_rdy, pend, ea_sum, e_cnt, ea_ovf);
        end
        if ({b_in_ready, b_out_valid, b_out_sum, b_out_count, b_out_overflow} !==
            {e_rdy, pend, eb_sum, e_cnt, eb_ovf}) begin
            miscompares++;
            $display("FAIL model_b t=%0t got rdy=%b v=%b sum=%0d cnt=%0d ovf=%b exp rdy=%b v=%b sum=%0d cnt=%0d ovf=%b",
                     $time, b_in_ready, b_out_valid, b_out_sum, b_out_count, b_out_overflow,
                     e_rdy, pend, eb_sum, e_cnt, eb_ovf);
        end
    end

    // Random-phase scoreboard: each delivered sum must match the next queued frame.
    logic [63:0] exp_q[$];
    bit          mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en && a_out_valid && out_ready) begin
            logic [63:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra got sum=%0d exp none", a_out_sum);
            end else begin
                e = exp_q.pop_front();
                if (a_out_sum !== 18'(e)) begin
                    miscompares++;
                    $display("FAIL sb_sum got %0d exp %0d", a_out_sum, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    // Present one product and hold it until accepted (bounded wait).
    task automatic beat(input logic [15:0] p, input logic last);
        bit r;
        int n = 0;
        in_valid = 1'b1; in_product = p; in_last = last;
        forever begin
            @(negedge clk); r = a_in_ready;
            @(posedge clk); #1;
            if (r) break;
            if (++n > 200) begin
                miscompares++;
                $display("FAIL beat_timeout product=%0d", p);
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        bit rnd_or;
        #7;
        chk("rst_in_ready", 32'(a_in_ready), 0);
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_sum", 32'(a_out_sum), 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(a_in_ready), 1);

        // Full frame ended by count.
        beat(16'd63, 0); beat(16'd144, 0); beat(16'd240, 0); beat(16'd65025, 0);
        chk("f1_valid", 32'(a_out_valid), 1);
        chk("f1_sum", 32'(a_out_sum), 65472);
        chk("f1_count", 32'(a_out_count), 4);
        chk("f1_ovf", 32'(a_out_overflow), 0);
        chk("f1_in_ready", 32'(a_in_ready), 0);
        drain();

        // Single zero product, result held under backpressure.
        beat(16'd0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("f2_hold_valid", 32'(a_out_valid), 1);
            chk("f2_hold_sum", 32'(a_out_sum), 0);
            chk("f2_hold_count", 32'(a_out_count), 1);
            chk("f2_hold_rdy", 32'(a_in_ready), 0);
        end
        drain();
        chk("f2_idle_valid", 32'(a_out_valid), 0);
        chk("f2_idle_rdy", 32'(a_in_ready), 1);

        // Wrap-around in the 16-bit instance, then overflow cleared next frame.
        beat(16'd65025, 0); beat(16'd65025, 1);
        chk("f3_b_sum", 32'(b_out_sum), 64514);
        chk("f3_b_ovf", 32'(b_out_overflow), 1);
        chk("f3_a_sum", 32'(a_out_sum), 130050);
        chk("f3_a_ovf", 32'(a_out_overflow), 0);
        drain();
        beat(16'd5, 1);
        chk("f4_b_sum", 32'(b_out_sum), 5);
        chk("f4_b_ovf", 32'(b_out_overflow), 0);
        drain();

        // Clear concurrent with a beat discards the whole frame.
        beat(16'd16, 0); beat(16'd0, 0);
        clear = 1'b1; in_valid = 1'b1; in_product = 16'd9;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 32'(a_out_valid), 0);
        @(posedge clk); #1;
        chk("clr_valid2", 32'(a_out_valid), 0);
        beat(16'd7, 0); beat(16'd9, 1);
        chk("f5_sum", 32'(a_out_sum), 16);
        chk("f5_count", 32'(a_out_count), 2);
        drain();

        // Asynchronous reset mid-frame.
        beat(16'd5, 0); beat(16'd6, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy", 32'(a_in_ready), 0);
        chk("arst_valid", 32'(a_out_valid), 0);
        chk("arst_sum", 32'(a_out_sum), 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        beat(16'd1, 0); beat(16'd2, 0); beat(16'd3, 0); beat(16'd4, 0);
        chk("f6_sum", 32'(a_out_sum), 10);
        chk("f6_count", 32'(a_out_count), 4);
        drain();

        // Randomised gaps and backpressure over 50 frames.
        mon_en = 1'b1;
        rnd_or = 1'b1;
        fork
            while (rnd_or) begin
                @(posedge clk); #1;
                if (rnd_or) out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int f = 0; f < 50; f++) begin
            int len;
            logic [63:0] s;
            logic [15:0] p;
            logic lst;
            len = $urandom_range(1, LEN);
            s = '0;
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                p = 16'($urandom_range(0, 65535));
                lst = (k == len - 1) && (len < LEN || 1'($urandom_range(0, 1)));
                s += 64'(p);
                if (k == len - 1) exp_q.push_back(s);
                beat(p, lst);
            end
        end
        rnd_or = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int n = 0; n < 50 && a_out_valid; n++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        out_ready = 1'b0;
        mon_en = 1'b0;
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of param_multiplier.
- Consumes the 2*WIDTH-bit unsigned product stream, one product per beat.
- Accumulates up to LEN products per frame into an ACC_WIDTH-bit sum, then presents the dot-product result on a valid/ready output.
- Frames end after LEN beats, or earlier on in_last.

Parameters:
- WIDTH, 8, operand width of upstream multiplier; product width is 2*WIDTH.
- LEN, 4, maximum products per frame (>=1).
- ACC_WIDTH, 18, accumulator width; must be >= 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; discards the current frame.
- in_valid  input  1  in_product/in_last valid.
- in_ready  output  1  block can accept a product.
- in_product  input  2*WIDTH  unsigned product from param_multiplier.
- in_last  input  1  marks final product of frame.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  ACC_WIDTH  accumulated sum (mod 2^ACC_WIDTH).
- out_count  output  $clog2(LEN+1)  number of products in frame.
- out_overflow  output  1  sum exceeded 2^ACC_WIDTH-1 during frame.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: in_ready=0 while rst_n low, then 1 in IDLE; out_valid=0, out_sum=0, out_count=0, out_overflow=0; state=IDLE.
- Definitions: in-transfer = in_valid && in_ready; out-transfer = out_valid && out_ready.
- States: IDLE (acc empty), ACCUM (>=1 product taken), HOLD (result presented).
- in_ready = 1 in IDLE/ACCUM, 0 in HOLD. in_ready is combinational from state only, never from in_valid.
- On in-transfer:
  - acc <= acc + zero-extended in_product.
  - count <= count+1.
  - overflow <= overflow | carry-out of the ACC_WIDTH add.
- Frame end: in-transfer with in_last=1, or with count==LEN-1 (the LEN-th beat). Next state is HOLD, with out_valid=1 from the following cycle.
- Other transitions:
  - Non-final in-transfer: IDLE->ACCUM; ACCUM stays ACCUM.
  - Latency: result visible one cycle after the final accepted beat.
- HOLD:
  - out_sum/out_count/out_overflow are registered and stable until out-transfer.
  - On out-transfer: next cycle IDLE, acc=0, count=0, overflow=0, out_valid=0.
  - No new product is accepted in the cycle out-transfer occurs (one-bubble turnaround).
- out_sum, out_count and out_overflow read 0 whenever out_valid=0.
- in_last in IDLE (single-product frame): result = that product, count=1.
- Wrap-around: sum wraps modulo 2^ACC_WIDTH; out_overflow flags it. overflow is sticky within the frame and cleared per frame.
- clear=1 (sync, priority over all handshakes): next cycle IDLE, acc/count/overflow=0, out_valid=0. Any in-transfer in the same cycle is discarded.
- rst_n low mid-frame or in HOLD: immediate return to reset values; the partial frame is lost.
- in_valid while in_ready=0: ignored. Upstream must hold the data until accepted.

Test Plan:
- Reset, then products 63, 144, 240, 65025 with in_valid continuous -> out_valid one cycle after 4th beat; out_sum=65472, out_count=4, out_overflow=0; in_ready=0 during HOLD.
- Single beat in_product=0, in_last=1 -> out_sum=0, out_count=1; with out_ready=0 for 5 cycles, outputs stable and in_ready=0; out_ready=1 -> IDLE next cycle.
- ACC_WIDTH=16 override; products 65025, 65025 with in_last on second -> out_sum=64514 (130050 mod 65536), out_overflow=1; next frame product 5 -> out_overflow=0.
- Products 16, 0 then clear=1 concurrent with in_valid product 9 -> no out_valid; next frame 7,9 (in_last) -> out_sum=16, out_count=2.
- rst_n pulsed low asynchronously (mid-cycle) after 2 of 4 beats -> outputs zero immediately; following full frame of 1,2,3,4 -> out_sum=10, out_count=4.
- Randomised in_valid/out_ready gaps over 50 frames -> every out_sum matches a model sum of accepted products; no product lost or duplicated.
